eth_reg_sequencer: RTL

- Command sequencer directly upstream of the KSZ-style register bus engine; it is the block that drives that engine's WR/offset/length/writeData/NewCommand/Dummy_* inputs.
- Walks an external command table of WRITE, READ, POLL and END entries, e.g. chip-ID check, MAC address load, TX/RX enable.
- Issues one bus access at a time and waits for the engine to return to its Wait state.
- Returns READ results and POLL pass/fail, and reports completion or timeout to the host logic.

---
 rtl/eth_seq_pkg.sv | 50 +++++
 rtl/eth_seq_rom.sv | 43 ++++
 rtl/eth_reg_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_seq_pkg.sv
// Shared definitions for the register-bus command sequencer and its table.
// Holds op codes, the engine Wait-state encoding, entry field layout and FSM states.
// Optional feature macro used by the sequencer: ETH_SEQ_DUMMY_EN (address-phase skipping).
package eth_seq_pkg;

  // One table entry: op[42:41] offset[40:33] length[32] data[31:16] mask[15:0]
  localparam int ENTRY_W = 43;

  localparam int OP_HI   = 42;
  localparam int OP_LO   = 41;
  localparam int OFF_HI  = 40;
  localparam int OFF_LO  = 33;
  localparam int LEN_BIT = 32;
  localparam int DATA_HI = 31;
  localparam int DATA_LO = 16;
  localparam int MASK_HI = 15;
  localparam int MASK_LO = 0;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_POLL  = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  // Engine state output value meaning "idle, ready for NewCommand"
  localparam logic [3:0] REGIO_WAIT = 4'b1001;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_CHECK,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  // Builds a table entry in the layout above.
  function automatic logic [ENTRY_W-1:0] mk_entry(
    input logic [1:0]  op,
    input logic [7:0]  off,
    input logic        len,
    input logic [15:0] dat,
    input logic [15:0] msk
  );
    return {op, off, len, dat, msk};
  endfunction

endpackage

// File: rtl/eth_seq_rom.sv
// Command table for the sequencer: chip-ID check, MAC address load, TX/RX enable.
// Ports: clk40m/reset (async, active-high); addr = entry index; data = entry, valid
// one cycle after addr (registered read). Unused addresses read back as END.
module eth_seq_rom
  import eth_seq_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic               clk40m,
  input  logic               reset,
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] lookup;

  always_comb begin
    lookup = mk_entry(OP_END, 8'h00, 1'b0, 16'h0000, 16'h0000);
    case (int'(addr))
      // Chip ID: family code in the upper 12 bits, revision ignored
      0: lookup = mk_entry(OP_POLL,  8'hC0, 1'b1, 16'h8870, 16'hFFF0);
      // MAC address 00:11:22:33:44:55, low word first
      1: lookup = mk_entry(OP_WRITE, 8'h10, 1'b1, 16'h4455, 16'h0000);
      2: lookup = mk_entry(OP_WRITE, 8'h12, 1'b1, 16'h2233, 16'h0000);
      3: lookup = mk_entry(OP_WRITE, 8'h14, 1'b1, 16'h0011, 16'h0000);
      // TX control, then RX control
      4: lookup = mk_entry(OP_WRITE, 8'h70, 1'b1, 16'h01EF, 16'h0000);
      5: lookup = mk_entry(OP_WRITE, 8'h74, 1'b1, 16'h7CE0, 16'h0000);
      // Read back TX control so the host can confirm the enable
      6: lookup = mk_entry(OP_READ,  8'h70, 1'b1, 16'h0000, 16'h0000);
      default: lookup = mk_entry(OP_END, 8'h00, 1'b0, 16'h0000, 16'h0000);
    endcase
  end

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else begin
      data <= lookup;
    end
  end

endmodule

// File: rtl/eth_reg_sequencer.sv
// Command sequencer feeding the register bus engine: walks a WRITE/READ/POLL/END table,
// one access at a time. Ports: start/busy/done/err/err_pc (host), rom_addr/rom_data (table,
// 1-cycle registered read), rd_valid/rd_data/rd_pc (READ results), WR/offset/length/writeData/
// NewCommand/Dummy_Write/Dummy_Read (to engine), readData/regio_state (from engine).
// Macro ETH_SEQ_DUMMY_EN: repeat accesses to the same offset/length skip the address phase.
// The enclosing system level inverts reset for the engine's active-low reset input.
module eth_reg_sequencer
  import eth_seq_pkg::*;
#(
  parameter int AW       = 5,
  parameter int POLL_MAX = 1000
) (
  input  logic               clk40m,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW-1:0]      err_pc,
  output logic [AW-1:0]      rom_addr,
  input  logic [ENTRY_W-1:0] rom_data,
  output logic               rd_valid,
  output logic [15:0]        rd_data,
  output logic [AW-1:0]      rd_pc,
  output logic               WR,
  output logic [7:0]         offset,
  output logic               length,
  output logic [15:0]        writeData,
  output logic               NewCommand,
  output logic               Dummy_Write,
  output logic               Dummy_Read,
  input  logic [15:0]        readData,
  input  logic [3:0]         regio_state
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
  localparam logic [AW-1:0]  PC_LAST   = '1;

  seq_state_t state, state_nxt;

  logic [AW-1:0]  pc, pc_nxt;
  logic [PCW-1:0] poll_cnt, poll_cnt_nxt;
  logic [1:0]     ent_op, ent_op_nxt;
  logic [15:0]    ent_data, ent_data_nxt;
  logic [15:0]    ent_mask, ent_mask_nxt;
  logic [15:0]    rd_latch, rd_latch_nxt;

  logic           busy_nxt, done_nxt, err_nxt;
  logic [AW-1:0]  err_pc_nxt;
  logic           rd_valid_nxt;
  logic [15:0]    rd_data_nxt;
  logic [AW-1:0]  rd_pc_nxt;
  logic           wr_nxt, length_nxt, newcmd_nxt;
  logic [7:0]     offset_nxt;
  logic [15:0]    wdata_nxt;

  logic           engine_wait;
  logic           start_ok;
  logic           issue_fire;
  logic           poll_hit;
  logic           advance;
  logic           fail;
  logic [1:0]     rom_op;

  assign engine_wait = (regio_state == REGIO_WAIT);
  assign rom_op      = rom_data[OP_HI:OP_LO];
  // FINISH and ERROR already show busy low, so a start there is a legitimate new run.
  assign start_ok    = start && (state == S_IDLE || state == S_FINISH || state == S_ERROR);
  assign issue_fire  = (state == S_ISSUE) && engine_wait;
  // The table is addressed straight from pc so the entry is valid in DECODE.
  assign rom_addr    = pc;

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      poll_cnt   <= '0;
      ent_op     <= '0;
      ent_data   <= '0;
      ent_mask   <= '0;
      rd_latch   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_pc     <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_pc      <= '0;
      WR         <= 1'b0;
      offset     <= '0;
      length     <= 1'b0;
      writeData  <= '0;
      NewCommand <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      poll_cnt   <= poll_cnt_nxt;
      ent_op     <= ent_op_nxt;
      ent_data   <= ent_data_nxt;
      ent_mask   <= ent_mask_nxt;
      rd_latch   <= rd_latch_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_pc     <= err_pc_nxt;
      rd_valid   <= rd_valid_nxt;
      rd_data    <= rd_data_nxt;
      rd_pc      <= rd_pc_nxt;
      WR         <= wr_nxt;
      offset     <= offset_nxt;
      length     <= length_nxt;
      writeData  <= wdata_nxt;
      NewCommand <= newcmd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    poll_cnt_nxt = poll_cnt;
    ent_op_nxt   = ent_op;
    ent_data_nxt = ent_data;
    ent_mask_nxt = ent_mask;
    rd_latch_nxt = rd_latch;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    err_pc_nxt   = err_pc;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    rd_pc_nxt    = rd_pc;
    wr_nxt       = WR;
    offset_nxt   = offset;
    length_nxt   = length;
    wdata_nxt    = writeData;
    newcmd_nxt   = 1'b0;
    poll_hit     = ((rd_latch & ent_mask) == (ent_data & ent_mask));
    advance      = 1'b0;
    fail         = 1'b0;

    case (state)
      S_IDLE, S_FINISH, S_ERROR: begin
        state_nxt = S_IDLE;
        if (start_ok) begin
          pc_nxt       = '0;
          poll_cnt_nxt = '0;
          err_nxt      = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = S_FETCH;
        end
      end

      S_FETCH: state_nxt = S_DECODE;

      S_DECODE: begin
        ent_op_nxt   = rom_op;
        ent_data_nxt = rom_data[DATA_HI:DATA_LO];
        ent_mask_nxt = rom_data[MASK_HI:MASK_LO];
        if (rom_op == OP_END) begin
          // done shows up in FINISH with busy already low
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_FINISH;
        end else begin
          wr_nxt     = (rom_op == OP_WRITE);
          offset_nxt = rom_data[OFF_HI:OFF_LO];
          length_nxt = rom_data[LEN_BIT];
          wdata_nxt  = rom_data[DATA_HI:DATA_LO];
          state_nxt  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (engine_wait) begin
          newcmd_nxt = 1'b1;
          state_nxt  = S_WAIT_START;
        end
      end

      // The engine may still report Wait while it samples NewCommand.
      S_WAIT_START: begin
        if (!engine_wait) state_nxt = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (engine_wait) begin
          rd_latch_nxt = readData;
          state_nxt    = S_CHECK;
        end
      end

      S_CHECK: begin
        case (ent_op)
          OP_READ: begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = rd_latch;
            rd_pc_nxt    = pc;
            advance      = 1'b1;
          end
          OP_POLL: begin
            if (poll_hit) begin
              poll_cnt_nxt = '0;
              advance      = 1'b1;
            end else if (poll_cnt == POLL_LAST) begin
              fail = 1'b1;
            end else begin
              poll_cnt_nxt = poll_cnt + 1'b1;
              state_nxt    = S_ISSUE;
            end
          end
          default: advance = 1'b1;
        endcase

        // Running off the end of the table without END is a table error, not a wrap.
        if (advance) begin
          if (pc == PC_LAST) begin
            fail = 1'b1;
          end else begin
            pc_nxt    = pc + 1'b1;
            state_nxt = S_FETCH;
          end
        end

        if (fail) begin
          err_nxt    = 1'b1;
          err_pc_nxt = pc;
          busy_nxt   = 1'b0;
          state_nxt  = S_ERROR;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ETH_SEQ_DUMMY_EN
  // Address of the previous access in this run; cleared on every accepted start.
  logic       prev_vld;
  logic [7:0] prev_offset;
  logic       prev_length;
  logic       same_addr;
  logic       poll_retry;

  assign same_addr  = prev_vld && (offset == prev_offset) && (length == prev_length);
  // poll_cnt is only non-zero while re-reading a POLL register
  assign poll_retry = (poll_cnt != '0);

  always_ff @(posedge clk40m or posedge reset) begin
    if (reset) begin
      prev_vld    <= 1'b0;
      prev_offset <= '0;
      prev_length <= 1'b0;
      Dummy_Write <= 1'b0;
      Dummy_Read  <= 1'b0;
    end else begin
      Dummy_Write <= 1'b0;
      Dummy_Read  <= 1'b0;
      if (start_ok) begin
        prev_vld <= 1'b0;
      end else if (issue_fire) begin
        // Registered alongside NewCommand so both reach the engine in the same cycle
        Dummy_Write <= WR && same_addr && !poll_retry;
        Dummy_Read  <= !WR && (same_addr || poll_retry);
        prev_vld    <= 1'b1;
        prev_offset <= offset;
        prev_length <= length;
      end
    end
  end
`else
  logic unused_issue;
  assign unused_issue = issue_fire;
  assign Dummy_Write  = 1'b0;
  assign Dummy_Read   = 1'b0;
`endif

endmodule
